i2c_frame_tracker: RTL and testbench
====================================

Name: i2c_frame_tracker

Overview:
Upstream protocol front end of the I2C subordinate. Oversamples SCL/SDA on the system clock, detects START and STOP conditions, and counts bit positions. It matches the 7-bit device address and captures the R/W bit, then sequences the transaction phases. The memory interface consumes i2c_state, clock_count, read_bit, write_bit and sda_en from this block, and the top level ORs this block's address-ACK drive into the SDA open-drain control.

Parameters:
DEV_ADDR, 7'h50, subordinate device address to match
SYNC_STAGES, 2, synchroniser flops per bus input (minimum 2)

Ports:
clk  in  1  system clock; must run at 10x SCL or faster
rst_n  in  1  reset: rst_n, asynchronous, active-low
sda_in  in  1  raw SDA pin level
scl_in  in  1  raw SCL pin level
i2c_state  out  4  current transaction phase (encoding in i2c_pkg)
clock_count  out  4  bit index within current byte: 0..7 data, 8 ACK slot
read_bit  out  1  address matched with R/W=1; held until STOP/START
write_bit  out  1  address matched with R/W=0; held until STOP/START
sda_en  out  1  subordinate owns SDA this bit (ACK slots it drives, read data bits)
addr_ack  out  1  1 = pull SDA low for device-address ACK
busy  out  1  high from START to STOP

Behaviour:
- Reset values: i2c_state=ST_IDLE, clock_count=0, read_bit=0, write_bit=0, sda_en=0, addr_ack=0, busy=0. Synchronisers reset to 1 (bus idle high).
- Synchronise both inputs through SYNC_STAGES flops, plus one history flop, for edge detection. Pin-to-event latency is SYNC_STAGES+1 clk.
- START: synced SDA 1->0 while synced SCL=1.
  - From any state, go to ST_DEV_ADDR.
  - clock_count=0, read_bit=write_bit=0, busy=1.
  - A repeated START is handled identically.
- STOP: synced SDA 0->1 while synced SCL=1.
  - From any state, go to ST_IDLE.
  - All outputs return to reset values.
- Sampling: shift SDA into an internal 8-bit shift register on the detected SCL rising edge, only while clock_count<8.
- clock_count advances on the detected SCL falling edge: 0->1->...->8->0. State transitions also occur only on SCL falling edges, except START and STOP. Outputs are therefore stable across every SCL rising edge.
- States and transitions (all on the SCL falling edge that ends the byte or the ACK):
  - ST_IDLE(0): ignore everything except START.
  - ST_DEV_ADDR(1): at count 7->8 end, compare shift[7:1] to DEV_ADDR.
    - Match: ST_DEV_ACK. Set write_bit=~shift[0], read_bit=shift[0].
    - Mismatch: ST_IGNORE.
  - ST_DEV_ACK(2): addr_ack=1, sda_en=1 for the count-8 slot.
    - Exit on that slot's falling edge: write -> ST_MEM_ADDR, read -> ST_READ_DATA.
  - ST_MEM_ADDR(3): after 8 bits -> ST_MEM_ACK.
  - ST_MEM_ACK(4): sda_en=1; the memory interface drives the ACK. Exit -> ST_WRITE_DATA.
  - ST_WRITE_DATA(5): after 8 bits -> ST_WRITE_ACK.
  - ST_WRITE_ACK(6): sda_en=1. Exit -> ST_WRITE_DATA; this loop repeats indefinitely.
  - ST_READ_DATA(7): sda_en=1 for counts 0..7. After 8 bits -> ST_READ_ACK.
  - ST_READ_ACK(8): sda_en=0 (the controller drives). Sample SDA on the SCL rise.
    - ACK (0): -> ST_READ_DATA.
    - NACK (1): -> ST_IGNORE.
  - ST_IGNORE(9): sda_en=0, addr_ack=0. Wait for START or STOP.
- addr_ack is high only in ST_DEV_ACK. sda_en is a pure function of state and clock_count.
- Simultaneous SCL edge and START/STOP in the same clk: START/STOP wins.
- Asserting reset mid-byte aborts immediately to reset values. After release, the block stays in ST_IDLE until a fresh START.
- SCL stretching is not supported; this block never drives SCL.

Decomposition:
- i2c_pkg:
  - enum i2c_state_t (4-bit) with the ST_* encodings above
  - ACK_SLOT=4'd8
  - default DEV_ADDR constant
  - memory_interface imports the same enum for its state compares.
- One natural sub-module: i2c_bus_sync. It holds the synchroniser and history flops and outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

Test Plan:
- Write address match: START, byte 0xA0, ACK clock -> addr_ack=1 and sda_en=1 during the count-8 slot. write_bit=1, read_bit=0. i2c_state 1->2->3. clock_count 0..8 then 0.
- Write data loop: after 0xA0, send mem addr 0x12, data 0x34, data 0x56, STOP -> state sequence 3,4,5,6,5,6,0. busy falls within 3 clk of STOP. write_bit clears.
- Read with NACK: START, 0xA1, ACK, 8 clocks, controller ACK (0), 8 clocks, controller NACK (1), STOP -> read_bit=1. sda_en=1 on counts 0..7 of both bytes. State 7->8->7->8->9->0.
- Address mismatch: START, 0xB0 -> addr_ack stays 0, sda_en stays 0, state 9. A following START plus 0xA1 gives a normal match.
- Repeated START: mid-ST_WRITE_DATA at count 4, START then 0xA1 -> clock_count resets to 0, write_bit=0, then read_bit=1 and state 7.
- Reset mid-transaction: rst_n=0 at count 5 of ST_MEM_ADDR -> all outputs at reset values within 0 clk. No state change after release until START.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C subordinate: transaction phase encoding,
// ACK slot index and the default device address.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_DEV_ADDR   = 4'd1,
        ST_DEV_ACK    = 4'd2,
        ST_MEM_ADDR   = 4'd3,
        ST_MEM_ACK    = 4'd4,
        ST_WRITE_DATA = 4'd5,
        ST_WRITE_ACK  = 4'd6,
        ST_READ_DATA  = 4'd7,
        ST_READ_ACK   = 4'd8,
        ST_IGNORE     = 4'd9
    } i2c_state_t;

    localparam logic [3:0] ACK_SLOT         = 4'd8;
    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h50;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises raw SCL/SDA into the clk domain and flags SCL edges and START/STOP.
// All flops reset high so a reset bus reads as idle.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & sda_d & ~sda_s;
    assign stop_det  = scl_s & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_frame_tracker.sv
// I2C subordinate front end: tracks START/STOP, bit position and transaction phase,
// matches the device address and tells the memory interface who owns SDA.
module i2c_frame_tracker
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic [3:0] i2c_state,
    output logic [3:0] clock_count,
    output logic       read_bit,
    output logic       write_bit,
    output logic       sda_en,
    output logic       addr_ack,
    output logic       busy
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_state_t state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [7:0] shift_q, shift_d;
    logic       read_q, read_d, write_q, write_d;
    logic       ack_q, ack_d;
    logic       bit_open_q, bit_open_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= 4'd0;
            shift_q    <= 8'd0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            ack_q      <= 1'b0;
            bit_open_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            read_q     <= read_d;
            write_q    <= write_d;
            ack_q      <= ack_d;
            bit_open_q <= bit_open_d;
        end
    end

    // bit_open keeps the SCL fall that closes a START hold from counting as a bit.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shift_d    = shift_q;
        read_d     = read_q;
        write_d    = write_q;
        ack_d      = ack_q;
        bit_open_d = bit_open_q;
        if (stop_det) begin
            state_d    = ST_IDLE;
            count_d    = 4'd0;
            read_d     = 1'b0;
            write_d    = 1'b0;
            bit_open_d = 1'b0;
        end else if (start_det) begin
            state_d    = ST_DEV_ADDR;
            count_d    = 4'd0;
            read_d     = 1'b0;
            write_d    = 1'b0;
            bit_open_d = 1'b0;
        end else if (state_q != ST_IDLE) begin
            if (scl_rise) begin
                bit_open_d = 1'b1;
                if (count_q < ACK_SLOT) shift_d = {shift_q[6:0], sda_s};
                else                    ack_d   = sda_s;
            end
            if (scl_fall && bit_open_q) begin
                bit_open_d = 1'b0;
                count_d    = (count_q == ACK_SLOT) ? 4'd0 : count_q + 4'd1;
                if (count_q == 4'd7) begin
                    case (state_q)
                        ST_DEV_ADDR: begin
                            if (shift_q[7:1] == DEV_ADDR) begin
                                state_d = ST_DEV_ACK;
                                read_d  = shift_q[0];
                                write_d = ~shift_q[0];
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                        ST_MEM_ADDR:   state_d = ST_MEM_ACK;
                        ST_WRITE_DATA: state_d = ST_WRITE_ACK;
                        ST_READ_DATA:  state_d = ST_READ_ACK;
                        default:       state_d = state_q;
                    endcase
                end else if (count_q == ACK_SLOT) begin
                    case (state_q)
                        ST_DEV_ACK:   state_d = read_q ? ST_READ_DATA : ST_MEM_ADDR;
                        ST_MEM_ACK:   state_d = ST_WRITE_DATA;
                        ST_WRITE_ACK: state_d = ST_WRITE_DATA;
                        ST_READ_ACK:  state_d = ack_q ? ST_IGNORE : ST_READ_DATA;
                        default:      state_d = state_q;
                    endcase
                end
            end
        end
    end

    always_comb begin
        sda_en = 1'b0;
        case (state_q)
            ST_DEV_ACK, ST_MEM_ACK, ST_WRITE_ACK: sda_en = 1'b1;
            ST_READ_DATA:                         sda_en = (count_q < ACK_SLOT);
            default:                              sda_en = 1'b0;
        endcase
    end

    assign i2c_state   = state_q;
    assign clock_count = count_q;
    assign read_bit    = read_q;
    assign write_bit   = write_q;
    assign addr_ack    = (state_q == ST_DEV_ACK);
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_frame_tracker.sv
// Bench for i2c_frame_tracker: bit-level bus driver with a transaction-level
// expectation of phase, bit index and SDA ownership for every SCL high period.
module tb_i2c_frame_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sda = 1'b1;
    logic       scl = 1'b1;
    logic [3:0] i2c_state, clock_count;
    logic       read_bit, write_bit, sda_en, addr_ack, busy;

    int n_cmp = 0;
    int n_err = 0;

    // transaction context of the reference model
    int byte_idx = 0;
    bit addr_ok  = 0;
    bit is_read  = 0;
    bit dead     = 0;

    always #5 clk = ~clk;

    i2c_frame_tracker #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sda_in      (sda),
        .scl_in      (scl),
        .i2c_state   (i2c_state),
        .clock_count (clock_count),
        .read_bit    (read_bit),
        .write_bit   (write_bit),
        .sda_en      (sda_en),
        .addr_ack    (addr_ack),
        .busy        (busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int st, input int cnt, input int rd,
                                 input int wr, input int en, input int ack, input int bz);
        chk({tag, ".state"}, int'(i2c_state), st);
        chk({tag, ".count"}, int'(clock_count), cnt);
        chk({tag, ".read_bit"}, int'(read_bit), rd);
        chk({tag, ".write_bit"}, int'(write_bit), wr);
        chk({tag, ".sda_en"}, int'(sda_en), en);
        chk({tag, ".addr_ack"}, int'(addr_ack), ack);
        chk({tag, ".busy"}, int'(busy), bz);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // phase expected while the data bits of the current byte are on the bus
    function automatic int data_phase();
        if (byte_idx == 0) return 1;
        if (dead)          return 9;
        if (is_read)       return 7;
        if (byte_idx == 1) return 3;
        return 5;
    endfunction

    // phase expected during the ACK slot of the current byte
    function automatic int ack_phase();
        if (byte_idx == 0) return addr_ok ? 2 : 9;
        if (dead)          return 9;
        if (is_read)       return 8;
        if (byte_idx == 1) return 4;
        return 6;
    endfunction

    task automatic do_start(input string tag);
        scl = 1'b0; wait_clk(5);
        sda = 1'b1; wait_clk(5);
        scl = 1'b1; wait_clk(5);
        sda = 1'b0; wait_clk(6);
        check_outputs(tag, 1, 0, 0, 0, 0, 0, 1);
        scl = 1'b0; wait_clk(5);
        byte_idx = 0;
        addr_ok  = 0;
        is_read  = 0;
        dead     = 0;
    endtask

    task automatic do_stop(input string tag);
        scl = 1'b0; wait_clk(5);
        sda = 1'b0; wait_clk(5);
        scl = 1'b1; wait_clk(5);
        sda = 1'b1; wait_clk(3);
        check_outputs(tag, 0, 0, 0, 0, 0, 0, 0);
        wait_clk(5);
    endtask

    // Send bits 0..nbits-1 of a byte slot; slot bit 8 is the ACK carrying ackv.
    task automatic send_byte(input string tag, input logic [7:0] b, input logic ackv,
                             input int nbits);
        bit in_ack;
        int st, rd, wr, en;
        if (byte_idx == 0) begin
            addr_ok = (b[7:1] == 7'h50);
            is_read = b[0];
        end
        for (int i = 0; i < nbits; i++) begin
            in_ack = (i == 8);
            sda = in_ack ? ackv : b[7-i];
            wait_clk(5);
            scl = 1'b1;
            wait_clk(6);
            st = in_ack ? ack_phase() : data_phase();
            rd = (addr_ok && is_read && (byte_idx > 0 || in_ack)) ? 1 : 0;
            wr = (addr_ok && !is_read && (byte_idx > 0 || in_ack)) ? 1 : 0;
            en = in_ack ? ((st == 2 || st == 4 || st == 6) ? 1 : 0) : ((st == 7) ? 1 : 0);
            check_outputs(tag, st, i, rd, wr, en, (st == 2) ? 1 : 0, 1);
            wait_clk(4);
            scl = 1'b0;
            wait_clk(5);
        end
        if (nbits == 9) begin
            if (byte_idx == 0 && !addr_ok) dead = 1;
            if (byte_idx > 0 && is_read && ackv) dead = 1;
            byte_idx++;
        end
    endtask

    initial begin
        logic [6:0] a;
        logic       rw;
        int         n;

        // reset state
        wait_clk(3);
        check_outputs("reset", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        wait_clk(5);
        check_outputs("post_reset", 0, 0, 0, 0, 0, 0, 0);

        // write: address, memory address, two data bytes
        do_start("wr_start");
        send_byte("wr_addr", 8'hA0, 1'b0, 9);
        send_byte("wr_mem", 8'h12, 1'b0, 9);
        send_byte("wr_d0", 8'h34, 1'b0, 9);
        send_byte("wr_d1", 8'h56, 1'b0, 9);
        do_stop("wr_stop");

        // read: ACK first byte, NACK second, then a byte while ignoring
        do_start("rd_start");
        send_byte("rd_addr", 8'hA1, 1'b0, 9);
        send_byte("rd_d0", 8'($urandom_range(0, 255)), 1'b0, 9);
        send_byte("rd_d1", 8'($urandom_range(0, 255)), 1'b1, 9);
        send_byte("rd_ign", 8'($urandom_range(0, 255)), 1'b1, 9);
        do_stop("rd_stop");

        // address mismatch, then a fresh START with a matching read
        do_start("mis_start");
        send_byte("mis_addr", 8'hB0, 1'b1, 9);
        send_byte("mis_ign", 8'h5A, 1'b1, 9);
        do_start("mis_restart");
        send_byte("mis_raddr", 8'hA1, 1'b0, 9);
        send_byte("mis_rd", 8'hC3, 1'b1, 9);
        do_stop("mis_stop");

        // repeated START in the middle of a write data byte
        do_start("rs_start");
        send_byte("rs_addr", 8'hA0, 1'b0, 9);
        send_byte("rs_mem", 8'h12, 1'b0, 9);
        send_byte("rs_part", 8'hF0, 1'b0, 4);
        do_start("rs_restart");
        send_byte("rs_raddr", 8'hA1, 1'b0, 9);
        send_byte("rs_rd", 8'h77, 1'b1, 9);
        do_stop("rs_stop");

        // asynchronous reset at bit 5 of the memory address byte
        do_start("ar_start");
        send_byte("ar_addr", 8'hA0, 1'b0, 9);
        send_byte("ar_mem", 8'h12, 1'b0, 5);
        #2 rst_n = 1'b0;
        #1 check_outputs("ar_in_reset", 0, 0, 0, 0, 0, 0, 0);
        wait_clk(3);
        sda = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sda = 1'($urandom_range(0, 1));
            wait_clk(5);
            scl = 1'b1;
            wait_clk(6);
            check_outputs("ar_after", 0, 0, 0, 0, 0, 0, 0);
            wait_clk(4);
            scl = 1'b0;
            wait_clk(5);
        end
        do_start("ar_recover");
        send_byte("ar_raddr", 8'hA0, 1'b0, 9);
        do_stop("ar_stop");

        // randomized transactions
        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = 7'h50;
            end else begin
                a = 7'($urandom_range(0, 127));
                while (a == 7'h50) a = 7'($urandom_range(0, 127));
            end
            rw = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 4);
            do_start("rnd_start");
            send_byte("rnd_addr", {a, rw}, 1'b0, 9);
            for (int j = 0; j < n; j++)
                send_byte("rnd_byte", 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 3) == 0), 9);
            do_stop("rnd_stop");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
